// File: rtl/medidor_frecuencia_pkg.sv
`default_nettype none
// ============================================================================
// Module      : medidor_pkg
// Description : Shared types and constants for the frequency meter.
//               Holds the FSM state type, the settle length in cycles and
//               the default no-edge timeout (1 s at 5 MHz).
// Revision    : 1.0 - initial release
// ============================================================================
package medidor_pkg;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

  // Cycles spent after reset while the synchronizer fills with real data.
  localparam int unsigned SETTLE_CYCLES = 3;

  // Default number of cnt steps tolerated without an edge.
  localparam logic [31:0] TIMEOUT_DEFAULT = 32'd5_000_000;

endpackage
`default_nettype wire

// File: rtl/medidor_frecuencia_if.sv
`default_nettype none
// ============================================================================
// Module      : medidor_frecuencia_if
// Description : Signal bundle between the frequency meter and its user.
//   sig_in    : asynchronous square wave to be measured
//   div_value : last measured half-period minus 1 (clk cycles)
//   phase     : level of sig_in during the reported half-period
//   valid     : one-cycle strobe, div_value/phase updated with it
//   timeout   : sticky, no edge seen within TIMEOUT+1 cycles
//   locked    : high while a measurement is running
//   master modport: the side that supplies sig_in and consumes results.
//   slave  modport: the meter itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface medidor_frecuencia_if #(
  parameter int unsigned WIDTH = 32
);
  logic             sig_in;
  logic [WIDTH-1:0] div_value;
  logic             phase;
  logic             valid;
  logic             timeout;
  logic             locked;

  modport master (
    output sig_in,
    input  div_value,
    input  phase,
    input  valid,
    input  timeout,
    input  locked
  );

  modport slave (
    input  sig_in,
    output div_value,
    output phase,
    output valid,
    output timeout,
    output locked
  );
endinterface
`default_nettype wire

// File: rtl/medidor_frecuencia_sincronizador_flanco.sv
`default_nettype none
// ============================================================================
// Module      : sincronizador_flanco
// Description : Two-flop synchronizer for an asynchronous input followed by
//               a delay flop, giving a both-edges detector in the clk domain.
//   clk       : system clock
//   reset     : synchronous, active-low reset
//   d_async_i : asynchronous input
//   level_o   : synchronized level (second flop)
//   prev_o    : synchronized level one cycle earlier (third flop)
//   edge_o    : level_o differs from prev_o (rising or falling edge)
// Revision    : 1.0 - initial release
// ============================================================================
module sincronizador_flanco (
  input  logic clk,
  input  logic reset,
  input  logic d_async_i,
  output logic level_o,
  output logic prev_o,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign prev_o  = s3_q;
  assign edge_o  = s2_q ^ s3_q;

endmodule
`default_nettype wire

// File: rtl/medidor_frecuencia.sv
`default_nettype none
// ============================================================================
// Module      : medidor_frecuencia
// Description : Measures half-periods of an asynchronous square wave in clk
//               cycles and reports each one as the divider threshold that
//               would regenerate it (half-period minus 1).
//   clk   : system clock (5 MHz nominal)
//   reset : synchronous, active-low reset
//   bus   : slave side of medidor_frecuencia_if (sig_in in; div_value,
//           phase, valid, timeout, locked out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module medidor_frecuencia
  import medidor_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(TIMEOUT_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 reset,
  medidor_frecuencia_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_SETTLE_LAST = WIDTH'(SETTLE_CYCLES - 1);

  logic w_level;
  logic w_prev;
  logic w_edge;
  // The synchronized level is kept on the sub-module for observability; the
  // FSM only needs the edge and the level preceding it.
  logic w_unused_level;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] div_q,     div_d;
  logic             phase_q,   phase_d;
  logic             valid_q,   valid_d;
  logic             timeout_q, timeout_d;
  logic             locked_q;

  sincronizador_flanco u_sync (
    .clk       (clk),
    .reset     (reset),
    .d_async_i (bus.sig_in),
    .level_o   (w_level),
    .prev_o    (w_prev),
    .edge_o    (w_edge)
  );

  assign w_unused_level = w_level;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= SETTLE;
      cnt_q     <= '0;
      div_q     <= '0;
      phase_q   <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      locked_q  <= (state_d == MEASURE);
    end
  end

  // cnt doubles as the settle counter, so SETTLE needs no extra register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    phase_d   = phase_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    unique case (state_q)
      SETTLE: begin
        if (cnt_q == c_SETTLE_LAST) begin
          state_d = ARM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_ONE;
        end
      end
      ARM: begin
        cnt_d = '0;
        if (w_edge) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // An edge coinciding with cnt == TIMEOUT is a valid measurement.
        if (w_edge) begin
          div_d     = cnt_q;
          phase_d   = w_prev;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == TIMEOUT) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ARM;
        end else begin
          cnt_d = cnt_q + c_ONE;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.div_value = div_q;
  assign bus.phase     = phase_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.locked    = locked_q;

endmodule
`default_nettype wire

// File: doc/medidor_frecuencia.md
# medidor_frecuencia

- Measures the half-periods of an external square wave in `clk` cycles.
- Reports each result as the threshold value that makes the codebase's frequency divider regenerate the same waveform.
- Sits on the receive side of divider-generated clocks: loop-back self-test of the divider chain, or measurement of external reference signals on the DE0-Nano-SoC fabric.
- Inputs are asynchronous; outputs are registered in the `clk` domain, with a valid strobe, the measured phase and a timeout flag.

## Interface

Parameters:
- `WIDTH`, 32: width of the count and of `div_value`.
- `TIMEOUT`, 32'd5_000_000: maximum `cnt` value without an edge before measurement is abandoned (1 s at 5 MHz).

Ports:
- `clk`  input  1: system clock, 5 MHz nominal.
- `reset`  input  1: synchronous, active-low reset (sampled on posedge `clk`).
- `sig_in`  input  1: asynchronous square wave to measure.
- `div_value`  output  WIDTH: last measured half-period minus 1, in `clk` cycles.
- `phase`  output  1: level of `sig_in` during the half-period in `div_value` (1 = high half).
- `valid`  output  1: one-cycle strobe; `div_value` and `phase` are updated in the same cycle.
- `timeout`  output  1: sticky flag, no edge seen within `TIMEOUT`+1 cycles.
- `locked`  output  1: high while in MEASURE.

## Operation

- **Synchronizer:** `sig_in` passes through two flops, `s1` then `s2`. A third flop `s3` holds the previous `s2`. `edge` = `s2 ^ s3`; both edges count.
- **FSM states:** SETTLE, ARM, MEASURE.
  - **SETTLE:** entered on reset. Lasts exactly 3 cycles while the synchronizer fills; `edge` is ignored; then goes to ARM.
  - **ARM:** `cnt` held at 0. On `edge`: `cnt` <= 0, go to MEASURE, no `valid`.
  - **MEASURE:**
    - On `edge`: `div_value` <= `cnt`, `phase` <= `s3`, `valid` <= 1, `timeout` <= 0, `cnt` <= 0.
    - Else if `cnt` == `TIMEOUT`: `timeout` <= 1, `cnt` <= 0, go to ARM.
    - Else `cnt` <= `cnt` + 1.
- **Arithmetic:**
  - Edges D cycles apart give `div_value` = D-1. This matches the divider, where threshold N toggles every N+1 cycles.
  - `cnt` never exceeds `TIMEOUT`, so it never wraps. `TIMEOUT` must be < 2^WIDTH.
- **Boundary conditions:**
  - `edge` and `cnt` == `TIMEOUT` in the same cycle: the edge wins. Measurement `TIMEOUT` is reported and `timeout` is not set.
  - `sig_in` toggling every clock (D=1): `div_value` = 0 and `valid` high every cycle.
  - After a timeout, the first edge only re-arms. The next edge produces the first new `valid`.
  - `div_value` and `phase` hold their last value through timeouts and re-arming.
  - Reset low mid-measurement: the cycle in progress is discarded and all state is cleared on the next posedge.
- **Reset values:** `div_value` = 0, `phase` = 0, `valid` = 0, `timeout` = 0, `locked` = 0. `s1`/`s2`/`s3` = 0, `cnt` = 0, state SETTLE.

## Timing

- Input to `edge`: a `sig_in` change captured by `s1` at posedge k is in `s2` at k+1; `edge` is high during cycle k+1..k+2.
- `edge` to `valid`: 1 cycle. Total `sig_in`-to-`valid` latency is 3 posedges, constant, so intervals are preserved exactly.
- Sampling jitter: measured half-periods may vary by ±1 cycle.
- `locked` rises the cycle after the arming edge and falls the cycle after a timeout.
- After reset deasserts, no `valid` can appear for SETTLE (3) + ARM (≥1) + one full half-period.
- Minimum measurable half-period: 1 cycle. Maximum: `TIMEOUT`+1 cycles.

## Structure

- **Package `medidor_pkg`:**
  - state enum: SETTLE, ARM, MEASURE.
  - `SETTLE_CYCLES` = 3.
  - default `TIMEOUT` constant.
- **Sub-module `sincronizador_flanco`:** contains the two-flop synchronizer plus the `s3` delay flop. Ports: `clk`, `reset`, `d_async`, `level` (= `s2`), `prev` (= `s3`), `edge`.
- **Top level:** FSM, `cnt` and output registers only.

## Test plan

1. Reset low for 5 cycles with `sig_in` = 1, then release → no `valid`, `locked` = 0 through SETTLE; `locked` rises after the first edge; all outputs 0 during reset.
2. `sig_in` toggling every 10 clocks, 50% duty (`TIMEOUT` = 100) → `valid` every 10 cycles, `div_value` = 9, `phase` alternating 1/0.
3. `sig_in` high 3 clocks, low 7 clocks, repeating → `div_value` alternates 2 (`phase` = 1) and 6 (`phase` = 0).
4. `TIMEOUT` = 100, `sig_in` frozen after arming → `timeout` = 1 and `locked` = 0, 101 cycles after the last `cnt` reset. Restart toggling every 4 clocks → first `valid` on the second edge, `div_value` = 3, `timeout` clears.
5. Edge arriving exactly when `cnt` = 100 → `valid` with `div_value` = 100; `timeout` stays 0; `locked` stays 1.
6. Loop-back: divider with threshold 24 drives `sig_in` → every `valid` reports `div_value` = 24. Reset pulsed low mid-half-period → outputs cleared, measurement resumes through SETTLE/ARM.
